// File: rtl/adau_audio_fifo.sv
// Stereo sample FIFO between the CPU bus writer and the ADAU I2S serializer.
// Reads are frame-paced by rd_req; an empty FIFO answers with a muted sample.
module adau_audio_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  input  logic                  flush,
  input  logic                  rd_req,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic [15:0]           underrun_count,
  output logic                  overflow,
  input  logic                  clear_status
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]       UNDER_MAX = 16'hFFFF;

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic [WIDTH-1:0]      rd_data_r;
  logic                  rd_data_valid_r;
  logic [15:0]           underrun_count_r;
  logic                  overflow_r;

  logic full_s;
  logic empty_s;
  logic wr_en_s;
  logic rd_en_s;
  logic underrun_s;
  logic drop_s;

  assign full_s  = (count_r == DEPTH_CNT);
  assign empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});

  assign full           = full_s;
  assign empty          = empty_s;
  assign level          = count_r;
  assign rd_data        = rd_data_r;
  assign rd_data_valid  = rd_data_valid_r;
  assign underrun_count = underrun_count_r;
  assign overflow       = overflow_r;

  // Event decode; full/empty are judged on the pre-edge count, flush masks everything
  always_comb begin
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    underrun_s = 1'b0;
    drop_s     = 1'b0;
    if (!flush) begin
      wr_en_s    = wr_valid && !full_s;
      drop_s     = wr_valid && full_s;
      rd_en_s    = rd_req && !empty_s;
      underrun_s = rd_req && empty_s;
    end else begin
      wr_en_s    = 1'b0;
      drop_s     = 1'b0;
      rd_en_s    = 1'b0;
      underrun_s = 1'b0;
    end
  end

  // Next occupancy from the accepted write/read pair
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // Sample storage; contents are deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
      end
      count_r <= count_nxt_s;
    end
  end

  // Serializer output: underruns present silence rather than a stale sample
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r       <= {WIDTH{1'b0}};
      rd_data_valid_r <= 1'b0;
    end else begin
      rd_data_valid_r <= rd_en_s || underrun_s;
      if (rd_en_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end else if (underrun_s) begin
        rd_data_r <= {WIDTH{1'b0}};
      end
    end
  end

  // Diagnostics; a same-cycle clear wins over a new event
  always_ff @(posedge clk) begin
    if (reset || clear_status) begin
      underrun_count_r <= 16'h0000;
      overflow_r       <= 1'b0;
    end else begin
      if (underrun_s && (underrun_count_r != UNDER_MAX)) begin
        underrun_count_r <= underrun_count_r + 16'h0001;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/adau_audio_fifo.md
Name: adau_audio_fifo

Overview:
- Stereo sample buffer between the CPU bus logic and the ADAU I2S serializer.
- Accepts 48-bit samples ({left[23:0], right[23:0]}), one per write strobe, from the bus side.
- Hands samples to the serializer on its per-frame request pulse.
- Reports full/level status back to the bus, plus underrun/overflow diagnostics.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 default).
- WIDTH, 48, sample width in bits; left channel in upper half.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_data  input  WIDTH  sample to enqueue.
- wr_valid  input  1  write strobe, one sample per high cycle.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  DEPTH_LOG2+1  current entry count, 0..DEPTH.
- flush  input  1  synchronous clear of stored samples.
- rd_req  input  1  one-cycle request pulse from serializer, once per audio frame.
- rd_data  output  WIDTH  sample presented to serializer.
- rd_data_valid  output  1  one-cycle pulse: rd_data updated.
- underrun_count  output  16  saturating count of requests that found FIFO empty.
- overflow  output  1  sticky: a write was dropped because FIFO was full.
- clear_status  input  1  clears underrun_count and overflow.

Behaviour:
- Interface: single clock clk; reset synchronous, active-high, sampled on rising edge of clk.
- Storage:
  - Circular buffer of DEPTH x WIDTH.
  - Write and read pointers are DEPTH_LOG2 bits wide and wrap naturally.
  - Count register is DEPTH_LOG2+1 bits wide.
- Status:
  - full = (count == DEPTH), empty = (count == 0), level = count.
  - All three are combinational from registered count, so they reflect state after the last edge.
- Reset values:
  - count 0, pointers 0, rd_data 0, rd_data_valid 0.
  - underrun_count 0, overflow 0.
  - So empty = 1, full = 0, level = 0.
- Write:
  - wr_valid && !full: store wr_data at wr_ptr, wr_ptr+1.
  - wr_valid && full: sample dropped, overflow <= 1; pointers unchanged.
- Read:
  - rd_req && !empty: rd_data <= mem[rd_ptr], rd_ptr+1, rd_data_valid <= 1 next cycle.
  - Latency is exactly 1 cycle from rd_req to updated rd_data/rd_data_valid.
- Underrun:
  - rd_req && empty: rd_data <= 0 (mute, never repeat stale sample), rd_data_valid <= 1.
  - underrun_count += 1, saturating at 16'hFFFF.
- rd_data holds its value between requests; rd_data_valid is high only in the cycle after rd_req.
- Simultaneous events:
  - Write and read, not full, not empty: both proceed, count unchanged.
  - Write and read while full: the write is dropped (full judged on pre-edge count), read proceeds, overflow set, count becomes DEPTH-1.
  - Write and read while empty: the read underruns (no write-through bypass), write stored, count becomes 1.
- Flush:
  - Pointers and count go to 0.
  - Writes and reads in the same cycle are ignored: no underrun counted, rd_data_valid 0.
  - rd_data and the status counters are kept.
- clear_status:
  - underrun_count <= 0, overflow <= 0.
  - If an underrun or overflow event occurs in the same cycle, clear_status takes priority.
- Reset mid-operation discards all stored samples; memory contents need not be cleared.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no gap; FIFO order is preserved across wrap.

Test Plan:
- Reset then idle -> empty=1, full=0, level=0, rd_data=0, underrun_count=0, overflow=0.
- Write 48'hAAAAAA_555555, then 48'h123456_FEDCBA; rd_req two times -> rd_data equals each sample in order, rd_data_valid pulses 1 cycle after each rd_req; level 2->1->0.
- Write 17 samples (values 1..17) with DEPTH 16 -> full=1 after the 16th write, 17th write dropped, overflow=1; 16 reads return 1..16.
- rd_req 3 times while empty -> rd_data=0 each time, underrun_count=3; assert clear_status -> 0; force 65537 underruns -> saturates at 16'hFFFF.
- Fill to 16, then write+rd_req in the same cycle -> write dropped, overflow=1, level=15. At level 0, write+rd_req together -> underrun, level=1.
- Wrap-around over 40 interleaved write/read pairs -> output sequence identical to input. Mid-stream flush with level 5 -> level=0; next rd_req underruns.
